// File: rtl/reg_read_port.sv
// ----------------------------------------------------------------------------
// reg_read_port
//
// Read side of the eight-entry register file. It accepts a two-operand read
// request (rA, rB) through a valid/ready handshake. Each operand is selected
// from r0..r7, and the result is captured into a 2-entry in-order output
// buffer. The block sits between instruction decode and execute.
//
// Optional feature (compile-time macro REG_READ_BYPASS_EN):
//   defined   -> same-cycle forwarding of the write data being committed.
//                The M port has priority over the E port.
//   undefined -> operands come only from r0..r7, and dstE/valE/dstM/valM are
//                ignored.
//
// Ports:
//   clock, reset      rising-edge clock; asynchronous active-high reset
//   r0..r7            current register file contents
//   dstE/valE         E-port write index/data (0..7 = write)
//   dstM/valM         M-port write index/data (0..7 = write)
//   req_valid/ready   request handshake; rA/rB are the operand indices
//   out_valid/ready   output handshake for the head entry
//   valA/valB         head entry operand values
//   errA/errB         head entry index was 8..14
//   rd_count          accepted-request counter, wraps modulo 2^16
// ----------------------------------------------------------------------------
module reg_read_port #(
  parameter int         WIDTH = 32,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  input  logic [WIDTH-1:0] r4,
  input  logic [WIDTH-1:0] r5,
  input  logic [WIDTH-1:0] r6,
  input  logic [WIDTH-1:0] r7,
  input  logic [3:0]       dstE,
  input  logic [WIDTH-1:0] valE,
  input  logic [3:0]       dstM,
  input  logic [WIDTH-1:0] valM,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic             errA,
  output logic             errB,
  output logic [15:0]      rd_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] head_a_q, head_b_q, tail_a_q, tail_b_q;
  logic             head_ea_q, head_eb_q, tail_ea_q, tail_eb_q;
  logic [15:0]      rd_count_q;

  logic [WIDTH-1:0] rf [8];
  logic [WIDTH-1:0] op_a_d, op_b_d;
  logic             err_a_d, err_b_d;
  logic             accept, pop;

  always_comb begin
    rf[0] = r0; rf[1] = r1; rf[2] = r2; rf[3] = r3;
    rf[4] = r4; rf[5] = r5; rf[6] = r6; rf[7] = r7;
  end

  // Operand select. An index with bit 3 set is either RNONE (no operand,
  // no error) or an illegal 8..14 index; both of these read as zero.
  always_comb begin
    op_a_d  = '0;
    op_b_d  = '0;
    err_a_d = 1'b0;
    err_b_d = 1'b0;
    if (!rA[3]) begin
      op_a_d = rf[rA[2:0]];
`ifdef REG_READ_BYPASS_EN
      // M wins over E, matching the register file's write priority.
      if (dstM == rA)      op_a_d = valM;
      else if (dstE == rA) op_a_d = valE;
`endif
    end else if (rA != RNONE) begin
      err_a_d = 1'b1;
    end
    if (!rB[3]) begin
      op_b_d = rf[rB[2:0]];
`ifdef REG_READ_BYPASS_EN
      if (dstM == rB)      op_b_d = valM;
      else if (dstE == rB) op_b_d = valE;
`endif
    end else if (rB != RNONE) begin
      err_b_d = 1'b1;
    end
  end

`ifndef REG_READ_BYPASS_EN
  // The write ports only matter when forwarding is compiled in.
  logic unused_bypass;
  assign unused_bypass = ^{dstE, valE, dstM, valM};
`endif

  // Handshakes depend only on the buffer state. There is no combinational
  // path from out_ready to req_ready.
  assign req_ready = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = req_valid && req_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      head_a_q   <= '0;
      head_b_q   <= '0;
      head_ea_q  <= 1'b0;
      head_eb_q  <= 1'b0;
      tail_a_q   <= '0;
      tail_b_q   <= '0;
      tail_ea_q  <= 1'b0;
      tail_eb_q  <= 1'b0;
      rd_count_q <= '0;
    end else begin
      if (accept) rd_count_q <= rd_count_q + 16'd1;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_a_q  <= op_a_d;
            head_b_q  <= op_b_d;
            head_ea_q <= err_a_d;
            head_eb_q <= err_b_d;
            state_q   <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            // The old head leaves while the new entry takes its place.
            head_a_q  <= op_a_d;
            head_b_q  <= op_b_d;
            head_ea_q <= err_a_d;
            head_eb_q <= err_b_d;
          end else if (accept) begin
            tail_a_q  <= op_a_d;
            tail_b_q  <= op_b_d;
            tail_ea_q <= err_a_d;
            tail_eb_q <= err_b_d;
            state_q   <= TWO;
          end else if (pop) begin
            state_q   <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_a_q  <= tail_a_q;
            head_b_q  <= tail_b_q;
            head_ea_q <= tail_ea_q;
            head_eb_q <= tail_eb_q;
            state_q   <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign valA     = head_a_q;
  assign valB     = head_b_q;
  assign errA     = head_ea_q;
  assign errB     = head_eb_q;
  assign rd_count = rd_count_q;

endmodule
